operand_stage: RTL

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_stage_pkg.sv | 75 +++++++
 rtl/operand_stage_shifter.sv | 80 ++++++++
 rtl/operand_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/operand_stage_pkg.sv
// Shared CPU definitions for the operand stage: FSM encoding, ARM opcodes,
// condition codes, shift types and the condition evaluator.
package operand_stage_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RS_READ = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    function automatic logic cond_pass(input logic [3:0] cond,
                                       input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            CC_EQ:   return z;
            CC_NE:   return !z;
            CC_CS:   return c;
            CC_CC:   return !c;
            CC_MI:   return n;
            CC_PL:   return !n;
            CC_VS:   return v;
            CC_VC:   return !v;
            CC_HI:   return c && !z;
            CC_LS:   return !c || z;
            CC_GE:   return n == v;
            CC_LT:   return n != v;
            CC_GT:   return !z && (n == v);
            CC_LE:   return z || (n != v);
            CC_AL:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/operand_stage_shifter.sv
// ARM barrel shifter: immediate-shift encodings (imm_form) and
// register-shift amounts, with carry-out.
import operand_stage_pkg::*;

module barrel_shifter (
    input  logic [31:0] value,
    input  shift_t      stype,
    input  logic [7:0]  amount,
    input  logic        imm_form,
    input  logic        cin,
    output logic [31:0] result,
    output logic        cout
);

    logic [4:0]  sh;
    logic        zero, over, is32;
    logic [32:0] lsl_w, lsr_w, asr_w;
    logic [31:0] ror_w;

    assign sh    = amount[4:0];
    assign zero  = amount == 8'd0;
    assign over  = |amount[7:5];
    assign is32  = amount == 8'd32;
    // carry rides in the extra bit of each widened shift
    assign lsl_w = {1'b0, value} << sh;
    assign lsr_w = {value, 1'b0} >> sh;
    assign asr_w = $signed({value, 1'b0}) >>> sh;
    assign ror_w = 32'({value, value} >> sh);

    always_comb begin
        result = value;
        cout   = cin;
        unique case (stype)
            SH_LSL: begin
                if (over) begin
                    result = '0;
                    cout   = is32 & value[0];
                end else if (!zero) begin
                    result = lsl_w[31:0];
                    cout   = lsl_w[32];
                end
            end
            SH_LSR: begin
                if ((imm_form && zero) || is32) begin
                    result = '0;
                    cout   = value[31];
                end else if (over) begin
                    result = '0;
                    cout   = 1'b0;
                end else if (!zero) begin
                    result = lsr_w[32:1];
                    cout   = lsr_w[0];
                end
            end
            SH_ASR: begin
                if ((imm_form && zero) || over) begin
                    result = {32{value[31]}};
                    cout   = value[31];
                end else if (!zero) begin
                    result = asr_w[32:1];
                    cout   = asr_w[0];
                end
            end
            SH_ROR: begin
                if (imm_form && zero) begin
                    result = {cin, value[31:1]};
                    cout   = value[0];
                end else if (!zero) begin
                    if (sh == 5'd0) begin
                        cout = value[31];
                    end else begin
                        result = ror_w;
                        cout   = ror_w[31];
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// ARM data-processing operand stage: condition check, register reads,
// operand-2 shifting and a valid/ready handshake towards the ALU.
import operand_stage_pkg::*;

module operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic [3:0]      cpsr_nzcv,
    output logic [3:0]      rf_raddr_a,
    output logic [3:0]      rf_raddr_b,
    input  logic [XLEN-1:0] rf_rdata_a,
    input  logic [XLEN-1:0] rf_rdata_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      opcode,
    output logic            setflags,
    output logic [3:0]      rd,
    output logic [XLEN-1:0] dataina,
    output logic [XLEN-1:0] datainb,
    output logic            shifter_carry
);

    state_t          state;
    logic [3:0]      op_q, rd_q, rs_q;
    logic            sf_q, c_q;
    shift_t          st_q;
    logic [XLEN-1:0] rn_q, rm_q;
    logic [7:0]      pc_lo_q;

    logic            regsh, go, accept;
    logic [XLEN-1:0] pc_off, rn_val, rm_val;
    logic [31:0]     sh_val, sh_res;
    shift_t          sh_type;
    logic [7:0]      sh_amt, rs_amt;
    logic            sh_imm, sh_cin, sh_cout;

    assign regsh  = !instr[25] && instr[4];
    // R15 reads see the pipeline offset, one word further in the 2-cycle form
    assign pc_off = pc + (regsh ? XLEN'(12) : XLEN'(8));
    assign rn_val = (instr[19:16] == 4'd15) ? pc_off : rf_rdata_a;
    assign rm_val = (instr[3:0] == 4'd15) ? pc_off : rf_rdata_b;
    assign rs_amt = (rs_q == 4'd15) ? pc_lo_q : rf_rdata_b[7:0];
    assign go     = cond_pass(instr[31:28], cpsr_nzcv)
                    && (instr[27:26] == 2'b00);

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready)
                      && !flush;
    assign accept   = in_valid && in_ready;

    assign rf_raddr_a = instr[19:16];
    assign rf_raddr_b = (state == S_RS_READ) ? rs_q : instr[3:0];

    always_comb begin
        sh_val  = rm_val;
        sh_type = shift_t'(instr[6:5]);
        sh_amt  = {3'b000, instr[11:7]};
        sh_imm  = 1'b1;
        sh_cin  = cpsr_nzcv[1];
        if (state == S_RS_READ) begin
            sh_val  = rm_q;
            sh_type = st_q;
            sh_amt  = rs_amt;
            sh_imm  = 1'b0;
            sh_cin  = c_q;
        end else if (instr[25]) begin
            sh_val  = {24'h0, instr[7:0]};
            sh_type = SH_ROR;
            sh_amt  = {3'b000, instr[11:8], 1'b0};
            sh_imm  = 1'b0;
        end
    end

    barrel_shifter u_shifter (
        .value    (sh_val),
        .stype    (sh_type),
        .amount   (sh_amt),
        .imm_form (sh_imm),
        .cin      (sh_cin),
        .result   (sh_res),
        .cout     (sh_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            out_valid     <= 1'b0;
            opcode        <= '0;
            setflags      <= 1'b0;
            rd            <= '0;
            dataina       <= '0;
            datainb       <= '0;
            shifter_carry <= 1'b0;
            op_q          <= '0;
            rd_q          <= '0;
            rs_q          <= '0;
            sf_q          <= 1'b0;
            c_q           <= 1'b0;
            st_q          <= SH_LSL;
            rn_q          <= '0;
            rm_q          <= '0;
            pc_lo_q       <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (state == S_RS_READ) begin
                opcode        <= op_q;
                setflags      <= sf_q;
                rd            <= rd_q;
                dataina       <= rn_q;
                datainb       <= sh_res;
                shifter_carry <= sh_cout;
                out_valid     <= 1'b1;
                state         <= S_IDLE;
            end else if (accept && go) begin
                if (regsh) begin
                    op_q    <= instr[24:21];
                    sf_q    <= instr[20];
                    rd_q    <= instr[15:12];
                    rs_q    <= instr[11:8];
                    st_q    <= shift_t'(instr[6:5]);
                    c_q     <= cpsr_nzcv[1];
                    rn_q    <= rn_val;
                    rm_q    <= rm_val;
                    pc_lo_q <= pc_off[7:0];
                    state   <= S_RS_READ;
                end else begin
                    opcode        <= instr[24:21];
                    setflags      <= instr[20];
                    rd            <= instr[15:12];
                    dataina       <= rn_val;
                    datainb       <= sh_res;
                    shifter_carry <= sh_cout;
                    out_valid     <= 1'b1;
                end
            end
        end
    end

endmodule
